// File: rtl/usb_rx_line_decoder.sv
// USB full-speed receive front end: synchronises D+/D-, recovers the bit clock at
// CLOCKS_PER_BIT oversampling, NRZI-decodes, unstuffs, checks SYNC and detects EOP/bus reset.
module usb_rx_line_decoder #(
  parameter int CLOCKS_PER_BIT = 4,
  parameter int SAMPLE_PHASE   = 2,
  parameter int RESET_CYCLES   = 120,
  parameter int IDLE_BITS      = 8
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       usb_d_p,
  input  logic       usb_d_n,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_end,
  output logic       rx_error,
  output logic       bus_reset
);
  localparam int PH_W = $clog2(CLOCKS_PER_BIT);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int IB_W = $clog2(IDLE_BITS + 1);

  localparam logic [1:0] L_J = 2'b10, L_K = 2'b01, L_SE0 = 2'b00, L_SE1 = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

  logic            dp_s1_q, dp_s2_q, dn_s1_q, dn_s2_q;
  logic [1:0]      line, line_prev_q;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            strobe, jk_edge, dec_bit;
  logic [7:0]      byte_nxt;
  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d, ones_q, ones_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            prev_jk_q, prev_jk_d;
  logic [RC_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [IB_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            se0_seen_q, se0_seen_d;
  logic            rx_active_q, rx_active_d, rx_valid_q, rx_valid_d;
  logic            rx_end_q, rx_end_d, rx_error_q, rx_error_d, bus_reset_q, bus_reset_d;
  logic [7:0]      rx_data_q, rx_data_d;

  function automatic logic [RC_W-1:0] se0_sat_inc(input logic [RC_W-1:0] cnt, input logic is_se0);
    if (!is_se0) return '0;
    if (cnt == RC_W'(RESET_CYCLES)) return cnt;
    return cnt + RC_W'(1);
  endfunction

  always_comb begin
    line     = {dp_s2_q, dn_s2_q};
    jk_edge  = (line == L_J && line_prev_q == L_K) || (line == L_K && line_prev_q == L_J);
    if (jk_edge || phase_q == PH_W'(CLOCKS_PER_BIT - 1)) phase_d = '0;
    else                                                  phase_d = phase_q + PH_W'(1);
    strobe   = (phase_d == PH_W'(SAMPLE_PHASE));
    // NRZI: no change of J/K level between samples decodes as 1
    dec_bit  = ((line == L_J) == prev_jk_q);
    byte_nxt = {dec_bit, shreg_q[7:1]};

    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    ones_d      = ones_q;
    shreg_d     = shreg_q;
    prev_jk_d   = prev_jk_q;
    idle_cnt_d  = (state_q == S_ERROR) ? idle_cnt_q : '0;
    se0_seen_d  = (state_q == S_ERROR) ? se0_seen_q : 1'b0;
    rx_active_d = rx_active_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_end_d    = 1'b0;
    rx_error_d  = 1'b0;
    se0_cnt_d   = se0_sat_inc(se0_cnt_q, line == L_SE0);
    bus_reset_d = (se0_cnt_d == RC_W'(RESET_CYCLES));

    if (bus_reset_d) begin
      state_d     = S_IDLE;
      rx_active_d = 1'b0;
    end else if (strobe) begin
      case (state_q)
        S_IDLE: if (line == L_K) begin
          // first K is SYNC bit 0, decoded against an implied preceding J
          state_d   = S_SYNC;
          prev_jk_d = 1'b0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bitcnt_d  = 3'd1;
        end
        S_SYNC: if (line == L_J || line == L_K) begin
          prev_jk_d = (line == L_J);
          shreg_d   = byte_nxt;
          bitcnt_d  = bitcnt_q + 3'd1;
          ones_d    = 3'd0;
          if (bitcnt_q == 3'd7) begin
            if (byte_nxt == 8'h80) begin
              state_d     = S_DATA;
              rx_active_d = 1'b1;
            end else begin
              state_d    = S_ERROR;
              rx_error_d = 1'b1;
            end
          end
        end else begin
          state_d    = S_ERROR;
          rx_error_d = 1'b1;
        end
        S_DATA: if (line == L_J || line == L_K) begin
          prev_jk_d = (line == L_J);
          if (ones_q == 3'd6) begin
            ones_d = 3'd0;
            if (dec_bit) begin
              state_d     = S_ERROR;
              rx_error_d  = 1'b1;
              rx_active_d = 1'b0;
            end
          end else begin
            ones_d   = dec_bit ? ones_q + 3'd1 : 3'd0;
            shreg_d  = byte_nxt;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_valid_d = 1'b1;
              rx_data_d  = byte_nxt;
            end
          end
        end else if (line == L_SE0) begin
          state_d = S_EOP;
        end else begin
          state_d     = S_ERROR;
          rx_error_d  = 1'b1;
          rx_active_d = 1'b0;
        end
        S_EOP: if (line == L_J) begin
          state_d     = S_IDLE;
          rx_end_d    = 1'b1;
          rx_error_d  = (bitcnt_q != 3'd0);
          rx_active_d = 1'b0;
        end else if (line != L_SE0) begin
          state_d     = S_ERROR;
          rx_error_d  = 1'b1;
          rx_active_d = 1'b0;
        end
        S_ERROR: begin
          rx_active_d = 1'b0;
          if (line == L_J) begin
            if (se0_seen_q || idle_cnt_q == IB_W'(IDLE_BITS - 1)) state_d = S_IDLE;
            else idle_cnt_d = idle_cnt_q + IB_W'(1);
          end else begin
            se0_seen_d = (line == L_SE0);
            idle_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock48) begin
    if (!reset_n) begin
      dp_s1_q     <= 1'b1;
      dp_s2_q     <= 1'b1;
      dn_s1_q     <= 1'b0;
      dn_s2_q     <= 1'b0;
      line_prev_q <= L_J;
      phase_q     <= '0;
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      ones_q      <= 3'd0;
      se0_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      se0_seen_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_end_q    <= 1'b0;
      rx_error_q  <= 1'b0;
      bus_reset_q <= 1'b0;
    end else begin
      dp_s1_q     <= usb_d_p;
      dp_s2_q     <= dp_s1_q;
      dn_s1_q     <= usb_d_n;
      dn_s2_q     <= dn_s1_q;
      line_prev_q <= line;
      phase_q     <= phase_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      ones_q      <= ones_d;
      se0_cnt_q   <= se0_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      se0_seen_q  <= se0_seen_d;
      rx_active_q <= rx_active_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_end_q    <= rx_end_d;
      rx_error_q  <= rx_error_d;
      bus_reset_q <= bus_reset_d;
    end
  end

  always_ff @(posedge clock48) begin
    shreg_q   <= shreg_d;
    prev_jk_q <= prev_jk_d;
  end

  assign rx_active = rx_active_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_end    = rx_end_q;
  assign rx_error  = rx_error_q;
  assign bus_reset = bus_reset_q;
endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Directed bench for usb_rx_line_decoder: builds NRZI/stuffed line waveforms bit by bit
// and checks strobe counts, received bytes, bus reset timing and error recovery.
module tb_usb_rx_line_decoder;
  logic       clock48 = 1'b0;
  logic       reset_n = 1'b0;
  logic       usb_d_p = 1'b1;
  logic       usb_d_n = 1'b0;
  logic       rx_active, rx_valid, rx_end, rx_error, bus_reset;
  logic [7:0] rx_data;

  usb_rx_line_decoder dut (
    .clock48(clock48), .reset_n(reset_n), .usb_d_p(usb_d_p), .usb_d_n(usb_d_n),
    .rx_active(rx_active), .rx_data(rx_data), .rx_valid(rx_valid), .rx_end(rx_end),
    .rx_error(rx_error), .bus_reset(bus_reset)
  );

  always #5 clock48 = ~clock48;

  localparam logic [1:0] SJ = 2'b10, SK = 2'b01, S0 = 2'b00;

  logic [1:0] syms[$];
  logic [1:0] lvl = SJ;
  int         ones = 0;
  int         n_chk = 0, n_pass = 0;

  // Strobe/level monitor sampling on the falling edge
  logic [7:0] vq[$];
  int  cyc = 0, m_valid = 0, m_end = 0, m_err = 0, m_end_err = 0, m_val_end = 0;
  int  m_br = 0, m_act = 0, m_any = 0, m_consec = 0, last_valid_cyc = 0, last_end_cyc = 0;
  logic pv = 1'b0, pe = 1'b0, pr = 1'b0;

  always @(negedge clock48) begin
    cyc <= cyc + 1;
    pv  <= rx_valid;
    pe  <= rx_end;
    pr  <= rx_error;
    if ((rx_valid && pv) || (rx_end && pe) || (rx_error && pr)) m_consec <= m_consec + 1;
    if (rx_valid) begin
      vq.push_back(rx_data);
      m_valid        <= m_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (rx_end) begin
      m_end        <= m_end + 1;
      last_end_cyc <= cyc;
    end
    if (rx_error)             m_err     <= m_err + 1;
    if (rx_end && rx_error)   m_end_err <= m_end_err + 1;
    if (rx_valid && rx_end)   m_val_end <= m_val_end + 1;
    if (bus_reset)            m_br      <= m_br + 1;
    if (rx_active)            m_act     <= m_act + 1;
    if (rx_active || rx_valid || rx_end || rx_error || bus_reset || rx_data != 8'h00)
      m_any <= m_any + 1;
  end

  int b_valid, b_end, b_err, b_end_err, b_br, b_act, b_any;
  task automatic snap();
    b_valid = m_valid; b_end = m_end; b_err = m_err; b_end_err = m_end_err;
    b_br = m_br; b_act = m_act; b_any = m_any;
  endtask

  task automatic add_sym(input logic [1:0] s, input int n);
    repeat (n) syms.push_back(s);
    lvl = s;
  endtask

  task automatic add_sync();
    syms.push_back(SK); syms.push_back(SJ); syms.push_back(SK); syms.push_back(SJ);
    syms.push_back(SK); syms.push_back(SJ); syms.push_back(SK); syms.push_back(SK);
    lvl  = SK;
    ones = 0;
  endtask

  task automatic add_bits(input logic [7:0] b, input int n, input bit stuff);
    for (int i = 0; i < n; i++) begin
      if (!b[i]) lvl = (lvl == SJ) ? SK : SJ;
      syms.push_back(lvl);
      if (stuff) begin
        if (b[i]) ones++;
        else      ones = 0;
        if (ones == 6) begin
          lvl = (lvl == SJ) ? SK : SJ;
          syms.push_back(lvl);
          ones = 0;
        end
      end
    end
  endtask

  task automatic add_eop();
    syms.push_back(S0); syms.push_back(S0); syms.push_back(SJ);
    lvl = SJ;
  endtask

  // Drive queued bits; odd-indexed bit boundaries are displaced by jit clocks.
  task automatic play(input int jit);
    int n;
    n = syms.size();
    for (int i = 0; i < n; i++) begin
      int oi, on, len;
      oi  = (i % 2 == 1) ? jit : 0;
      on  = ((i + 1) % 2 == 1 && i + 1 < n) ? jit : 0;
      len = 4 + on - oi;
      for (int c = 0; c < len; c++) begin
        @(negedge clock48);
        {usb_d_p, usb_d_n} = syms[i];
      end
    end
    syms.delete();
  endtask

  task automatic drive_clocks(input logic [1:0] s, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock48);
      {usb_d_p, usb_d_n} = s;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {usb_d_p, usb_d_n} = SJ;
    repeat (4) @(negedge clock48);
    reset_n = 1'b1;
    n_chk++;
    if ({rx_active, rx_valid, rx_end, rx_error, bus_reset, rx_data} !== 13'h0)
      $display("FAIL reset_outputs got=%h exp=0", {rx_active, rx_valid, rx_end, rx_error, bus_reset, rx_data});
    else n_pass++;
    snap();
    repeat (100) @(negedge clock48);
    n_chk++;
    if (m_any - b_any !== 0) $display("FAIL reset_quiet active_cycles=%0d exp=0", m_any - b_any);
    else n_pass++;
  endtask

  task automatic test_basic_packet();
    snap();
    add_sym(SJ, 4); add_sync(); add_bits(8'hC3, 8, 1'b1); add_eop(); add_sym(SJ, 6);
    play(0);
    n_chk++; if (m_valid - b_valid !== 1) $display("FAIL basic_valid_cnt got=%0d exp=1", m_valid - b_valid); else n_pass++;
    n_chk++; if (vq[b_valid] !== 8'hC3) $display("FAIL basic_data got=%h exp=c3", vq[b_valid]); else n_pass++;
    n_chk++; if (m_end - b_end !== 1) $display("FAIL basic_end_cnt got=%0d exp=1", m_end - b_end); else n_pass++;
    n_chk++; if (m_err - b_err !== 0) $display("FAIL basic_err_cnt got=%0d exp=0", m_err - b_err); else n_pass++;
    n_chk++; if (m_act - b_act !== 44) $display("FAIL basic_active_cycles got=%0d exp=44", m_act - b_act); else n_pass++;
    n_chk++; if (rx_active !== 1'b0) $display("FAIL basic_active_after got=%b exp=0", rx_active); else n_pass++;
    n_chk++; if (!(last_valid_cyc < last_end_cyc)) $display("FAIL basic_order valid_cyc=%0d end_cyc=%0d", last_valid_cyc, last_end_cyc); else n_pass++;
    n_chk++; if (m_br - b_br !== 0) $display("FAIL basic_eop_busreset got=%0d exp=0", m_br - b_br); else n_pass++;
  endtask

  task automatic test_stuffing(input int jit);
    logic [31:0] got;
    snap();
    add_sym(SJ, 4); add_sync();
    add_bits(8'hFF, 8, 1'b1); add_bits(8'h01, 8, 1'b1);
    add_bits(8'hFC, 8, 1'b1); add_bits(8'h7E, 8, 1'b1);
    add_eop(); add_sym(SJ, 6);
    play(jit);
    got = {vq[b_valid], vq[b_valid + 1], vq[b_valid + 2], vq[b_valid + 3]};
    n_chk++; if (m_valid - b_valid !== 4) $display("FAIL stuff_valid_cnt jit=%0d got=%0d exp=4", jit, m_valid - b_valid); else n_pass++;
    n_chk++; if (got !== 32'hFF01FC7E) $display("FAIL stuff_data jit=%0d got=%h exp=ff01fc7e", jit, got); else n_pass++;
    n_chk++; if ((m_err - b_err) * 10 + (m_end - b_end) !== 1)
      $display("FAIL stuff_err_end jit=%0d err=%0d end=%0d exp err=0 end=1", jit, m_err - b_err, m_end - b_end);
    else n_pass++;
  endtask

  task automatic test_stuff_error();
    snap();
    add_sym(SJ, 4); add_sync(); add_bits(8'hFF, 8, 1'b0); add_bits(8'h55, 8, 1'b0);
    play(0);
    repeat (8) @(negedge clock48);
    n_chk++; if (m_err - b_err !== 1) $display("FAIL stufferr_err_cnt got=%0d exp=1", m_err - b_err); else n_pass++;
    n_chk++; if (m_valid - b_valid !== 0) $display("FAIL stufferr_no_valid got=%0d exp=0", m_valid - b_valid); else n_pass++;
    n_chk++; if (rx_active !== 1'b0) $display("FAIL stufferr_active got=%b exp=0", rx_active); else n_pass++;
    add_eop(); add_sym(SJ, 10); add_sync(); add_bits(8'h5A, 8, 1'b1); add_eop(); add_sym(SJ, 4);
    play(0);
    n_chk++; if (m_valid - b_valid !== 1) $display("FAIL stufferr_recover_valid got=%0d exp=1", m_valid - b_valid); else n_pass++;
    n_chk++; if (vq[b_valid] !== 8'h5A) $display("FAIL stufferr_recover_data got=%h exp=5a", vq[b_valid]); else n_pass++;
    n_chk++; if (m_end - b_end !== 1) $display("FAIL stufferr_recover_end got=%0d exp=1", m_end - b_end); else n_pass++;
    n_chk++; if (m_err - b_err !== 1) $display("FAIL stufferr_total_err got=%0d exp=1", m_err - b_err); else n_pass++;
  endtask

  task automatic test_bad_sync();
    snap();
    add_sym(SJ, 4);
    for (int i = 0; i < 4; i++) begin syms.push_back(SK); syms.push_back(SJ); end
    add_sym(SJ, 12);
    play(0);
    n_chk++; if (m_err - b_err !== 1) $display("FAIL badsync_err got=%0d exp=1", m_err - b_err); else n_pass++;
    n_chk++; if (m_act - b_act !== 0) $display("FAIL badsync_active got=%0d exp=0", m_act - b_act); else n_pass++;
  endtask

  task automatic test_partial_eop();
    snap();
    add_sym(SJ, 2); add_sync(); add_bits(8'hC3, 8, 1'b1); add_bits(8'h05, 3, 1'b1);
    add_eop(); add_sym(SJ, 4);
    play(0);
    n_chk++; if (m_valid - b_valid !== 1) $display("FAIL partial_valid_cnt got=%0d exp=1", m_valid - b_valid); else n_pass++;
    n_chk++; if (vq[b_valid] !== 8'hC3) $display("FAIL partial_data got=%h exp=c3", vq[b_valid]); else n_pass++;
    n_chk++; if (m_end - b_end !== 1) $display("FAIL partial_end got=%0d exp=1", m_end - b_end); else n_pass++;
    n_chk++; if (m_err - b_err !== 1) $display("FAIL partial_err got=%0d exp=1", m_err - b_err); else n_pass++;
    n_chk++; if (m_end_err - b_end_err !== 1) $display("FAIL partial_end_err_same got=%0d exp=1", m_end_err - b_end_err); else n_pass++;
    n_chk++; if (!(last_valid_cyc < last_end_cyc)) $display("FAIL partial_order valid_cyc=%0d end_cyc=%0d", last_valid_cyc, last_end_cyc); else n_pass++;
  endtask

  task automatic test_bus_reset();
    snap();
    drive_clocks(SJ, 8);
    drive_clocks(S0, 130);
    drive_clocks(SJ, 30);
    n_chk++; if (m_br - b_br !== 11) $display("FAIL busrst_cycles got=%0d exp=11", m_br - b_br); else n_pass++;
    n_chk++; if (bus_reset !== 1'b0) $display("FAIL busrst_drop got=%b exp=0", bus_reset); else n_pass++;
    n_chk++; if ((m_end - b_end) + (m_err - b_err) !== 0) $display("FAIL busrst_strobes got=%0d exp=0", (m_end - b_end) + (m_err - b_err)); else n_pass++;
  endtask

  task automatic test_bus_reset_mid_packet();
    snap();
    add_sym(SJ, 4); add_sync(); add_bits(8'hC3, 8, 1'b1);
    play(0);
    drive_clocks(S0, 200);
    drive_clocks(SJ, 40);
    n_chk++; if (m_br - b_br !== 81) $display("FAIL midbus_cycles got=%0d exp=81", m_br - b_br); else n_pass++;
    n_chk++; if (m_valid - b_valid !== 1) $display("FAIL midbus_valid got=%0d exp=1", m_valid - b_valid); else n_pass++;
    n_chk++; if (m_end - b_end !== 0) $display("FAIL midbus_no_end got=%0d exp=0", m_end - b_end); else n_pass++;
    n_chk++; if (m_err - b_err !== 0) $display("FAIL midbus_no_err got=%0d exp=0", m_err - b_err); else n_pass++;
    n_chk++; if (rx_active !== 1'b0) $display("FAIL midbus_active got=%b exp=0", rx_active); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    snap();
    add_sym(SJ, 4); add_sync(); add_bits(8'h0A, 4, 1'b1);
    play(0);
    n_chk++; if (rx_active !== 1'b1) $display("FAIL midrst_active_before got=%b exp=1", rx_active); else n_pass++;
    reset_n = 1'b0;
    drive_clocks(SJ, 3);
    reset_n = 1'b1;
    drive_clocks(SJ, 40);
    n_chk++; if (rx_active !== 1'b0) $display("FAIL midrst_active_after got=%b exp=0", rx_active); else n_pass++;
    n_chk++; if ((m_end - b_end) + (m_err - b_err) !== 0) $display("FAIL midrst_strobes got=%0d exp=0", (m_end - b_end) + (m_err - b_err)); else n_pass++;
    n_chk++; if (m_valid - b_valid !== 0) $display("FAIL midrst_valid got=%0d exp=0", m_valid - b_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    snap();
    add_sym(SJ, 2); add_sync(); add_bits(8'hA5, 8, 1'b1); add_eop();
    add_sync(); add_bits(8'h3C, 8, 1'b1); add_eop(); add_sym(SJ, 4);
    play(0);
    got = {vq[b_valid], vq[b_valid + 1]};
    n_chk++; if (m_valid - b_valid !== 2) $display("FAIL b2b_valid_cnt got=%0d exp=2", m_valid - b_valid); else n_pass++;
    n_chk++; if (got !== 16'hA53C) $display("FAIL b2b_data got=%h exp=a53c", got); else n_pass++;
    n_chk++; if (m_end - b_end !== 2) $display("FAIL b2b_end_cnt got=%0d exp=2", m_end - b_end); else n_pass++;
    n_chk++; if (m_err - b_err !== 0) $display("FAIL b2b_err_cnt got=%0d exp=0", m_err - b_err); else n_pass++;
  endtask

  task automatic test_strobe_rules();
    n_chk++; if (m_consec !== 0) $display("FAIL strobe_consecutive got=%0d exp=0", m_consec); else n_pass++;
    n_chk++; if (m_val_end !== 0) $display("FAIL valid_end_overlap got=%0d exp=0", m_val_end); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_stuffing(0);
    test_stuffing(1);
    test_stuffing(-1);
    test_stuff_error();
    test_bad_sync();
    test_partial_eop();
    test_bus_reset();
    test_bus_reset_mid_packet();
    test_reset_mid_packet();
    test_back_to_back();
    test_strobe_rules();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
